// File: rtl/conv3_result_streamer.sv
// Streams the conv-3 result frame out of result BRAM port A onto a valid/ready interface.
// Optional STREAM_CHECKSUM_EN appends one wrap-around checksum beat after the data words.
`timescale 1ns/1ps
module conv3_result_streamer #(
  parameter int unsigned DATA_SIZE  = 16,
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned BASE_ADDR  = 7880,
  parameter int unsigned WORD_COUNT = 120,
  parameter int unsigned READ_WAIT  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_SIZE-1:0]  result_bram_douta,
  output logic                  result_bram_ena,
  output logic                  result_bram_wea,
  output logic [ADDR_WIDTH-1:0] result_bram_addra,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_SIZE-1:0]  m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IW = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam int unsigned WW = $clog2(READ_WAIT + 1);
  localparam logic [IW-1:0]         LAST_IDX = IW'(WORD_COUNT - 1);
  localparam logic [WW-1:0]         CAP_CNT  = WW'(READ_WAIT - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           index_q, index_d;
  logic [WW-1:0]           wait_q,  wait_d;
  logic                    ena_q,   ena_d;
  logic [ADDR_WIDTH-1:0]   addra_q, addra_d;
  logic                    valid_q, valid_d;
  logic [DATA_SIZE-1:0]    data_q,  data_d;
  logic                    last_q,  last_d;
`ifdef STREAM_CHECKSUM_EN
  logic [DATA_SIZE-1:0]    sum_q,   sum_d;
  logic                    chk_q,   chk_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      wait_q  <= '0;
      ena_q   <= 1'b0;
      addra_q <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      wait_q  <= wait_d;
      ena_q   <= ena_d;
      addra_q <= addra_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

`ifdef STREAM_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      chk_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      chk_q <= chk_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    wait_d  = wait_q;
    ena_d   = ena_q;
    addra_d = addra_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
`ifdef STREAM_CHECKSUM_EN
    sum_d   = sum_q;
    chk_d   = chk_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ena_d   = 1'b1;
          addra_d = BASE;
          wait_d  = '0;
          state_d = S_WAIT;
`ifdef STREAM_CHECKSUM_EN
          sum_d   = '0;
          chk_d   = 1'b0;
`endif
        end
      end
      S_WAIT: begin
        wait_d = wait_q + WW'(1);
        if (wait_q == CAP_CNT) begin
          data_d  = result_bram_douta;
          valid_d = 1'b1;
          ena_d   = 1'b0;
          state_d = S_SEND;
`ifdef STREAM_CHECKSUM_EN
          last_d  = 1'b0;
`else
          last_d  = (index_q == LAST_IDX);
`endif
        end
      end
      S_SEND: begin
        if (m_ready) begin
`ifdef STREAM_CHECKSUM_EN
          if (chk_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            chk_d   = 1'b0;
            state_d = S_DONE;
          end else if (index_q == LAST_IDX) begin
            // Checksum beat reuses the output register; valid stays high.
            sum_d  = sum_q + data_q;
            data_d = sum_q + data_q;
            last_d = 1'b1;
            chk_d  = 1'b1;
          end else begin
            sum_d   = sum_q + data_q;
            index_d = index_q + IW'(1);
            ena_d   = 1'b1;
            addra_d = BASE + ADDR_WIDTH'(index_q) + ADDR_WIDTH'(1);
            valid_d = 1'b0;
            wait_d  = '0;
            state_d = S_WAIT;
          end
`else
          if (index_q == LAST_IDX) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = S_DONE;
          end else begin
            index_d = index_q + IW'(1);
            ena_d   = 1'b1;
            addra_d = BASE + ADDR_WIDTH'(index_q) + ADDR_WIDTH'(1);
            valid_d = 1'b0;
            wait_d  = '0;
            state_d = S_WAIT;
          end
`endif
        end
      end
      S_DONE: begin
        index_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign result_bram_ena   = ena_q;
  assign result_bram_wea   = 1'b0;
  assign result_bram_addra = addra_q;
  assign m_valid           = valid_q;
  assign m_data            = data_q;
  assign m_last            = last_q;
  assign busy              = (state_q != S_IDLE);
  assign done              = (state_q == S_DONE);

endmodule

// File: tb/tb_conv3_result_streamer.sv
// Self-checking bench for conv3_result_streamer: BRAM model plus an expected-beat list built from memory contents.
// Also covers the STREAM_CHECKSUM_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_conv3_result_streamer;
  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 13;
  localparam int unsigned BASE = 7880;
  localparam int unsigned N    = 120;
  localparam int unsigned RW   = 3;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, m_ready = 1'b0;
  logic [DW-1:0] douta, r1;
  logic          ena, wea, m_valid, m_last, busy, done;
  logic [AW-1:0] addra;
  logic [DW-1:0] m_data;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            vectors = 0, miscompares = 0, cyc = 0;
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];

  conv3_result_streamer #(
    .DATA_SIZE(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .WORD_COUNT(N), .READ_WAIT(RW)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .result_bram_douta(douta), .result_bram_ena(ena), .result_bram_wea(wea),
    .result_bram_addra(addra),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Read data is valid two edges after the address edge, so the DUT samples it on the third.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    r1    <= ena ? mem[addra] : 16'hDEAD;
    douta <= r1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ena"}, ena, 0);
    chk({tag, "_wea"}, wea, 0);
    chk({tag, "_addra"}, addra, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  function automatic void build_expected();
    logic [DW-1:0] sum;
    sum = '0;
    exp_data.delete();
    exp_last.delete();
    for (int i = 0; i < int'(N); i++) begin
      exp_data.push_back(mem[BASE + i]);
      exp_last.push_back(i == int'(N) - 1);
      sum = sum + mem[BASE + i];
    end
`ifdef STREAM_CHECKSUM_EN
    exp_last[N-1] = 1'b0;
    exp_data.push_back(sum);
    exp_last.push_back(1'b1);
`endif
  endfunction

  // mode 0: m_ready held high; mode 1: 20-cycle stall on beat 0 then random ready.
  task automatic run_frame(input int mode, input int poke_beat, input int abort_beat);
    int beat = 0, stall = 0, last_new = 0, cyc0, nexp;
    bit hs_pending = 0, have_held = 0, done_seen = 0, ena_prev = 0, finished = 0;
    logic [DW-1:0] held_d = '0;
    logic          held_l = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    build_expected();
    nexp = exp_data.size();
    @(negedge clk);
    chk("idle_busy", busy, 0);
    start   = 1'b1;
    m_ready = (mode == 0);
    @(negedge clk);
    start = 1'b0;
    cyc0  = cyc;
    chk("busy_after_start", busy, 1);
    for (int c = 0; c < 6000 && !finished; c++) begin
      start = 1'b0;
      if (hs_pending) begin
        beat++;
        hs_pending = 0;
        have_held  = 0;
      end
      chk("wea_low", wea, 0);
      if (ena && !ena_prev) chk("addra_issue", addra, AW'(BASE + beat));
      if (ena && ena_prev)  chk("addra_hold", addra, addr_prev);
      if (m_valid)          chk("ena_low_while_valid", ena, 0);
      if (done_seen) begin
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
        chk("valid_after_done", m_valid, 0);
        finished = 1;
      end else if (done) begin
        chk("done_after_last", beat, nexp);
        chk("valid_in_done", m_valid, 0);
        chk("busy_in_done", busy, 1);
        done_seen = 1;
        start     = 1'b1;
      end else begin
        chk("busy_in_frame", busy, 1);
        if (m_valid) begin
          if (!have_held) begin
            if (beat < nexp) begin
              chk("beat_data", m_data, exp_data[beat]);
              chk("beat_last", m_last, exp_last[beat]);
            end else begin
              chk("extra_beat", beat, nexp - 1);
            end
            if (beat == 0) chk("first_latency", cyc - cyc0, RW);
            else if (mode == 0 && beat < int'(N)) chk("beat_spacing", cyc - last_new, RW + 1);
            last_new  = cyc;
            held_d    = m_data;
            held_l    = m_last;
            have_held = 1;
            if (beat == poke_beat) start = 1'b1;
            if (beat == abort_beat) begin
              #1 rst = 1'b1;
              #1 check_all_zero("abort");
              @(negedge clk);
              chk("no_done_after_abort", done, 0);
              rst     = 1'b0;
              m_ready = 1'b0;
              return;
            end
          end else begin
            chk("hold_data", m_data, held_d);
            chk("hold_last", m_last, held_l);
          end
          if (mode == 0) m_ready = 1'b1;
          else if (beat == 0 && stall < 20) begin
            m_ready = 1'b0;
            stall++;
          end else m_ready = 1'($urandom_range(0, 1));
          if (m_ready) hs_pending = 1;
        end else begin
          if (have_held) chk("valid_dropped", m_valid, 1);
          m_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
      end
      ena_prev  = ena;
      addr_prev = addra;
      if (!finished) @(negedge clk);
    end
    chk("frame_finished", finished, 1);
    repeat (2) begin
      @(negedge clk);
      chk("stays_idle_busy", busy, 0);
      chk("stays_idle_ena", ena, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < int'(N); i++) mem[BASE + i] = DW'(i + 1);
    run_frame(0, 50, -1);

    for (int i = 0; i < int'(N); i++) mem[BASE + i] = DW'($urandom);
    run_frame(1, -1, -1);

    for (int i = 0; i < int'(N); i++) mem[BASE + i] = DW'(i + 1);
    run_frame(0, -1, 60);
    run_frame(1, -1, -1);

`ifdef STREAM_CHECKSUM_EN
    for (int i = 0; i < int'(N); i++) mem[BASE + i] = 16'hFFFF;
    run_frame(0, -1, -1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
